// File: rtl/icache_fill_engine.sv
// Instruction cache fill engine: fetches one line as a stream of 32-bit word
// reads, packs it into a full line and writes it through the cache fill port.
// Also sequences the CACHEDEPTH-cycle flush pulse used by the valid-bit sweep.
module icache_fill_engine #(
  parameter int LOG2CACHELINESIZE = 7,
  parameter int LOG2CACHEDEPTH    = 6
) (
  input  logic                                mem_clk,
  input  logic                                reset,
  input  logic                                miss_req,
  input  logic [31:0]                         miss_addr,
  output logic                                fill_busy,
  output logic                                fill_done,
  input  logic                                flush_req,
  output logic                                bus_flush,
  output logic                                mem_rd_en,
  output logic [31:0]                         mem_rd_addr,
  input  logic                                mem_rd_wait,
  input  logic                                mem_rd_valid,
  input  logic [31:0]                         mem_rd_data,
  output logic [31:0]                         mem_filladdr,
  output logic [(2**LOG2CACHELINESIZE)-1:0]   mem_filldata,
  output logic                                mem_fillwe
);

  localparam int CACHELINESIZE = 2 ** LOG2CACHELINESIZE;
  localparam int WORDS         = CACHELINESIZE / 32;
  localparam int LOG2WORDS     = LOG2CACHELINESIZE - 5;
  localparam int CW            = LOG2WORDS + 1;
  localparam int LINEOFF       = LOG2CACHELINESIZE - 3;

  localparam logic [CW-1:0]             WORDS_C    = CW'(WORDS);
  localparam logic [CW-1:0]             LAST_WORD  = CW'(WORDS - 1);
  localparam logic [LOG2CACHEDEPTH-1:0] DEPTH_LAST = '1;
  localparam logic [31:0]               LINE_MASK  = ~((32'd1 << LINEOFF) - 32'd1);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    FETCH,
    FILL
  } state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 line_addr_q, line_addr_d;
  logic [CW-1:0]               issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]               recv_cnt_q, recv_cnt_d;
  logic [LOG2CACHEDEPTH-1:0]   depth_cnt_q, depth_cnt_d;
  logic                        flush_pend_q, flush_pend_d;
  logic [CACHELINESIZE-1:0]    filldata_q, filldata_d;
  logic                        rd_en_w;

  // Every output is decoded from registered state so nothing is combinational from an input.
  assign rd_en_w      = (state_q == FETCH) && (issue_cnt_q < WORDS_C);
  assign mem_rd_en    = rd_en_w;
  assign mem_rd_addr  = line_addr_q + 32'({issue_cnt_q, 2'b00});
  assign fill_busy    = (state_q != IDLE);
  assign bus_flush    = (state_q == FLUSH);
  assign mem_fillwe   = (state_q == FILL);
  assign fill_done    = (state_q == FILL);
  assign mem_filladdr = line_addr_q;
  assign mem_filldata = filldata_q;

  // Next-state logic: flush has priority in IDLE, issue and receive sides run independently in FETCH.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    issue_cnt_d  = issue_cnt_q;
    recv_cnt_d   = recv_cnt_q;
    depth_cnt_d  = depth_cnt_q;
    flush_pend_d = flush_pend_q | flush_req;
    filldata_d   = filldata_q;

    case (state_q)
      IDLE: begin
        if (flush_pend_q || flush_req) begin
          state_d      = FLUSH;
          depth_cnt_d  = '0;
          flush_pend_d = 1'b0;
        end else if (miss_req) begin
          state_d     = FETCH;
          line_addr_d = miss_addr & LINE_MASK;
          issue_cnt_d = '0;
          recv_cnt_d  = '0;
        end
      end

      FLUSH: begin
        depth_cnt_d = depth_cnt_q + 1'b1;
        if (depth_cnt_q == DEPTH_LAST) begin
          state_d     = IDLE;
          depth_cnt_d = '0;
        end
      end

      FETCH: begin
        if (rd_en_w && !mem_rd_wait) begin
          issue_cnt_d = issue_cnt_q + 1'b1;
        end
        if (mem_rd_valid) begin
          for (int w = 0; w < WORDS; w++) begin
            if (recv_cnt_q == CW'(w)) begin
              filldata_d[32*w +: 32] = mem_rd_data;
            end
          end
          recv_cnt_d = recv_cnt_q + 1'b1;
          if (recv_cnt_q == LAST_WORD) begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; synchronous reset discards any partially assembled line.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      line_addr_q  <= '0;
      issue_cnt_q  <= '0;
      recv_cnt_q   <= '0;
      depth_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      filldata_q   <= '0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      issue_cnt_q  <= issue_cnt_d;
      recv_cnt_q   <= recv_cnt_d;
      depth_cnt_q  <= depth_cnt_d;
      flush_pend_q <= flush_pend_d;
      filldata_q   <= filldata_d;
    end
  end

endmodule

// File: tb/tb_icache_fill_engine.sv
// Directed testbench for icache_fill_engine with a behavioural word-read memory
// (configurable latency and alternate-cycle stall) returning address-as-data.
module tb_icache_fill_engine;

  logic         mem_clk;
  logic         reset;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         fill_busy;
  logic         fill_done;
  logic         flush_req;
  logic         bus_flush;
  logic         mem_rd_en;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_wait;
  logic         mem_rd_valid;
  logic [31:0]  mem_rd_data;
  logic [31:0]  mem_filladdr;
  logic [127:0] mem_filldata;
  logic         mem_fillwe;

  icache_fill_engine #(
    .LOG2CACHELINESIZE(7),
    .LOG2CACHEDEPTH(6)
  ) dut (
    .mem_clk     (mem_clk),
    .reset       (reset),
    .miss_req    (miss_req),
    .miss_addr   (miss_addr),
    .fill_busy   (fill_busy),
    .fill_done   (fill_done),
    .flush_req   (flush_req),
    .bus_flush   (bus_flush),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_wait (mem_rd_wait),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data (mem_rd_data),
    .mem_filladdr(mem_filladdr),
    .mem_filldata(mem_filldata),
    .mem_fillwe  (mem_fillwe)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } beat_t;

  beat_t        pendQ[$];
  logic [31:0]  reqAddrs[$];
  int           cyc;
  int           latency;
  bit           waitAlt;
  bit           injectBeat;

  int           fillCount;
  logic [31:0]  lastFillAddr;
  logic [127:0] lastFillData;
  int           lastFillCyc;
  int           flushCycles;
  int           busyCycles;
  int           flushStarts;
  int           lastFlushStartCyc;
  bit           prevFlush;

  int           checks;
  int           passed;

  // One cycle of simulation: observe DUT outputs mid-cycle, then drive the memory side.
  task automatic applyStimulus();
    @(negedge mem_clk);
    cyc++;
    if (mem_fillwe === 1'b1) begin
      fillCount++;
      lastFillAddr = mem_filladdr;
      lastFillData = mem_filldata;
      lastFillCyc  = cyc;
    end
    if (bus_flush === 1'b1) begin
      flushCycles++;
      if (!prevFlush) begin
        flushStarts++;
        lastFlushStartCyc = cyc;
      end
    end
    prevFlush = (bus_flush === 1'b1);
    if (fill_busy === 1'b1) busyCycles++;

    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    if (pendQ.size() > 0 && pendQ[0].due == cyc) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = pendQ[0].data;
      void'(pendQ.pop_front());
    end else if (injectBeat) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hDEAD_BEEF;
    end
    mem_rd_wait = waitAlt && ((cyc % 2) == 1);
    if (mem_rd_en === 1'b1 && !mem_rd_wait) begin
      reqAddrs.push_back(mem_rd_addr);
      pendQ.push_back('{cyc + latency, mem_rd_addr});
    end
  endtask

  task automatic clearObs();
    reqAddrs.delete();
    fillCount         = 0;
    lastFillAddr      = 32'h0;
    lastFillData      = '0;
    lastFillCyc       = -1;
    flushCycles       = 0;
    busyCycles        = 0;
    flushStarts       = 0;
    lastFlushStartCyc = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL reset_fill_busy: got %b expected 0", fill_busy); else passed++;
    checks++; if (fill_done !== 1'b0) $display("[TB] FAIL reset_fill_done: got %b expected 0", fill_done); else passed++;
    checks++; if (bus_flush !== 1'b0) $display("[TB] FAIL reset_bus_flush: got %b expected 0", bus_flush); else passed++;
    checks++; if (mem_rd_en !== 1'b0) $display("[TB] FAIL reset_rd_en: got %b expected 0", mem_rd_en); else passed++;
    checks++; if (mem_fillwe !== 1'b0) $display("[TB] FAIL reset_fillwe: got %b expected 0", mem_fillwe); else passed++;
    checks++; if (mem_rd_addr !== 32'h0) $display("[TB] FAIL reset_rd_addr: got %h expected 0", mem_rd_addr); else passed++;
    checks++; if (mem_filladdr !== 32'h0) $display("[TB] FAIL reset_filladdr: got %h expected 0", mem_filladdr); else passed++;
    checks++; if (mem_filldata !== 128'h0) $display("[TB] FAIL reset_filldata: got %h expected 0", mem_filldata); else passed++;
    clearObs();
    injectBeat = 1'b1;
    repeat (4) applyStimulus();
    injectBeat = 1'b0;
    repeat (3) applyStimulus();
    checks++; if (fillCount !== 0) $display("[TB] FAIL idle_beat_fills: got %0d expected 0", fillCount); else passed++;
    checks++; if (busyCycles !== 0) $display("[TB] FAIL idle_beat_busy: got %0d expected 0", busyCycles); else passed++;
    checks++; if (mem_filldata !== 128'h0) $display("[TB] FAIL idle_beat_data: got %h expected 0", mem_filldata); else passed++;
  endtask

  task automatic test_miss_basic();
    int acceptCyc;
    logic [31:0] got;
    latency = 1;
    waitAlt = 1'b0;
    clearObs();
    applyStimulus();
    miss_req  = 1'b1;
    miss_addr = 32'h0000_1234;
    acceptCyc = cyc;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      if (k == 1) begin
        checks++; if (fill_busy !== 1'b1) $display("[TB] FAIL basic_busy: got %b expected 1", fill_busy); else passed++;
      end
      if (mem_fillwe === 1'b1) miss_req = 1'b0;
    end
    miss_req = 1'b0;
    checks++; if (reqAddrs.size() !== 4) $display("[TB] FAIL basic_req_count: got %0d expected 4", reqAddrs.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < reqAddrs.size()) ? reqAddrs[i] : 32'hFFFF_FFFF;
      checks++; if (got !== 32'h1230 + 32'(4*i)) $display("[TB] FAIL basic_req_addr%0d: got %h expected %h", i, got, 32'h1230 + 32'(4*i)); else passed++;
    end
    checks++; if (fillCount !== 1) $display("[TB] FAIL basic_fill_count: got %0d expected 1", fillCount); else passed++;
    checks++; if (lastFillAddr !== 32'h1230) $display("[TB] FAIL basic_filladdr: got %h expected 00001230", lastFillAddr); else passed++;
    checks++; if (lastFillData !== 128'h0000123C_00001238_00001234_00001230) $display("[TB] FAIL basic_filldata: got %h expected 0000123c00001238000012340000123 0", lastFillData); else passed++;
    checks++; if (lastFillCyc - acceptCyc !== 6) $display("[TB] FAIL basic_latency: got %0d expected 6", lastFillCyc - acceptCyc); else passed++;
    checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL basic_idle_after: got %b expected 0", fill_busy); else passed++;
  endtask

  task automatic test_miss_wait();
    logic [31:0] got;
    latency = 3;
    waitAlt = 1'b1;
    clearObs();
    applyStimulus();
    miss_req  = 1'b1;
    miss_addr = 32'h0000_1234;
    for (int k = 1; k <= 30; k++) begin
      applyStimulus();
      if (mem_fillwe === 1'b1) miss_req = 1'b0;
    end
    miss_req = 1'b0;
    waitAlt  = 1'b0;
    checks++; if (reqAddrs.size() !== 4) $display("[TB] FAIL wait_req_count: got %0d expected 4", reqAddrs.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      got = (i < reqAddrs.size()) ? reqAddrs[i] : 32'hFFFF_FFFF;
      checks++; if (got !== 32'h1230 + 32'(4*i)) $display("[TB] FAIL wait_req_addr%0d: got %h expected %h", i, got, 32'h1230 + 32'(4*i)); else passed++;
    end
    checks++; if (fillCount !== 1) $display("[TB] FAIL wait_fill_count: got %0d expected 1", fillCount); else passed++;
    checks++; if (lastFillData !== 128'h0000123C_00001238_00001234_00001230) $display("[TB] FAIL wait_filldata: got %h expected 0000123c000012380000123400001230", lastFillData); else passed++;
  endtask

  task automatic test_flush_alone();
    int reqCyc;
    clearObs();
    applyStimulus();
    flush_req = 1'b1;
    reqCyc    = cyc;
    applyStimulus();
    flush_req = 1'b0;
    repeat (79) applyStimulus();
    checks++; if (flushCycles !== 64) $display("[TB] FAIL flush_cycles: got %0d expected 64", flushCycles); else passed++;
    checks++; if (busyCycles !== 64) $display("[TB] FAIL flush_busy_cycles: got %0d expected 64", busyCycles); else passed++;
    checks++; if (lastFlushStartCyc - reqCyc !== 1) $display("[TB] FAIL flush_start: got %0d expected 1", lastFlushStartCyc - reqCyc); else passed++;
    checks++; if (flushStarts !== 1) $display("[TB] FAIL flush_starts: got %0d expected 1", flushStarts); else passed++;
  endtask

  task automatic test_flush_during_fetch();
    latency = 1;
    waitAlt = 1'b0;
    clearObs();
    applyStimulus();
    miss_req  = 1'b1;
    miss_addr = 32'h0000_2008;
    for (int k = 1; k <= 100; k++) begin
      applyStimulus();
      flush_req = (k == 2 || k == 4);
      if (mem_fillwe === 1'b1) miss_req = 1'b0;
    end
    flush_req = 1'b0;
    miss_req  = 1'b0;
    checks++; if (fillCount !== 1) $display("[TB] FAIL ff_fill_count: got %0d expected 1", fillCount); else passed++;
    checks++; if (lastFillAddr !== 32'h2000) $display("[TB] FAIL ff_filladdr: got %h expected 00002000", lastFillAddr); else passed++;
    checks++; if (lastFillData !== 128'h0000200C_00002008_00002004_00002000) $display("[TB] FAIL ff_filldata: got %h expected 0000200c000020080000200400002000", lastFillData); else passed++;
    checks++; if (flushStarts !== 1) $display("[TB] FAIL ff_flush_starts: got %0d expected 1", flushStarts); else passed++;
    checks++; if (flushCycles !== 64) $display("[TB] FAIL ff_flush_cycles: got %0d expected 64", flushCycles); else passed++;
    checks++; if (lastFlushStartCyc - lastFillCyc !== 2) $display("[TB] FAIL ff_flush_after_fill: got %0d expected 2", lastFlushStartCyc - lastFillCyc); else passed++;
  endtask

  task automatic test_reset_mid_fetch();
    latency = 1;
    waitAlt = 1'b0;
    clearObs();
    applyStimulus();
    miss_req  = 1'b1;
    miss_addr = 32'h0000_1230;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      if (k == 4) begin
        reset    = 1'b1;
        miss_req = 1'b0;
      end else if (k == 5) begin
        reset = 1'b0;
      end
    end
    checks++; if (fillCount !== 0) $display("[TB] FAIL rst_fill_count: got %0d expected 0", fillCount); else passed++;
    checks++; if (fill_busy !== 1'b0) $display("[TB] FAIL rst_busy: got %b expected 0", fill_busy); else passed++;
    checks++; if (mem_filldata !== 128'h0) $display("[TB] FAIL rst_filldata: got %h expected 0", mem_filldata); else passed++;
    clearObs();
    miss_req  = 1'b1;
    miss_addr = 32'h0000_0040;
    for (int k = 1; k <= 12; k++) begin
      applyStimulus();
      if (mem_fillwe === 1'b1) miss_req = 1'b0;
    end
    miss_req = 1'b0;
    checks++; if (fillCount !== 1) $display("[TB] FAIL rst_refill_count: got %0d expected 1", fillCount); else passed++;
    checks++; if (lastFillAddr !== 32'h40) $display("[TB] FAIL rst_refill_addr: got %h expected 00000040", lastFillAddr); else passed++;
    checks++; if (lastFillData !== 128'h0000004C_00000048_00000044_00000040) $display("[TB] FAIL rst_refill_data: got %h expected 0000004c000000480000004400000040", lastFillData); else passed++;
  endtask

  // Runs the scenarios in order and prints the single summary line.
  initial begin
    reset        = 1'b1;
    miss_req     = 1'b0;
    miss_addr    = 32'h0;
    flush_req    = 1'b0;
    mem_rd_wait  = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = 32'h0;
    cyc          = 0;
    latency      = 1;
    waitAlt      = 1'b0;
    injectBeat   = 1'b0;
    prevFlush    = 1'b0;
    checks       = 0;
    passed       = 0;
    clearObs();

    $display("[TB] starting icache_fill_engine tests");
    test_reset();
    test_miss_basic();
    test_miss_wait();
    test_flush_alone();
    test_flush_during_fetch();
    test_reset_mid_fetch();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
